ber_checker: RTL



---
 rtl/ber_checker_if.sv | 35 +++
 rtl/ber_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ber_checker_if.sv
// +--------------------------------------------------------------------+
// | Module      : ber_checker_if                                       |
// | Description : Strobe/bit inputs and counter/lock outputs of the    |
// |               bit-error-rate checker, bundled as one interface.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

interface ber_checker_if #(
    parameter int LAT_W = 9,
    parameter int CNT_W = 64
);
    logic             i_valid;
    logic             enable;
    logic             i_ref_bit;
    logic             i_rx_bit;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] bit_count;
    logic [LAT_W-1:0] min_latency;
    logic             locked;

    // Driver side: supplies strobes and bits, observes results
    modport master (
        output i_valid, enable, i_ref_bit, i_rx_bit,
        input  error_count, bit_count, min_latency, locked
    );

    // Checker side
    modport slave (
        input  i_valid, enable, i_ref_bit, i_rx_bit,
        output error_count, bit_count, min_latency, locked
    );
endinterface

`default_nettype wire

// File: rtl/ber_checker.sv
// +--------------------------------------------------------------------+
// | Module      : ber_checker                                          |
// | Description : Compares received bits against a delayed PRBS        |
// |               reference, searches for the latency with the fewest  |
// |               errors, locks on it and accumulates bit/error counts.|
// |               Optional macro BER_RESYNC_EN: drop lock and re-search|
// |               when a WINDOW-strobe block sees > WINDOW/2 errors.   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module ber_checker #(
    parameter int MAX_LAT = 511,
    parameter int LAT_W   = 9,
    parameter int WINDOW  = 32,
    parameter int CNT_W   = 64
) (
    input  wire logic   clock,
    input  wire logic   reset,
    ber_checker_if.slave bus
);

    localparam int c_WCNT_W = $clog2(WINDOW);
    localparam int c_WERR_W = $clog2(WINDOW + 1);

    localparam logic [LAT_W-1:0]    c_MAX_LAT  = LAT_W'(MAX_LAT);
    localparam logic [c_WCNT_W-1:0] c_WIN_LAST = c_WCNT_W'(WINDOW - 1);
`ifdef BER_RESYNC_EN
    localparam logic [c_WERR_W-1:0] c_WIN_HALF = c_WERR_W'(WINDOW / 2);
`endif

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCK   = 1'b1
    } state_t;

    state_t              state_q,       state_d;
    logic [MAX_LAT-1:0]  ref_sr_q,      ref_sr_d;
    logic [LAT_W-1:0]    cand_q,        cand_d;
    logic [LAT_W-1:0]    best_lat_q,    best_lat_d;
    logic [c_WERR_W-1:0] best_err_q,    best_err_d;
    logic [c_WCNT_W-1:0] win_cnt_q,     win_cnt_d;
    logic [c_WERR_W-1:0] win_err_q,     win_err_d;
    logic [CNT_W-1:0]    bit_count_q,   bit_count_d;
    logic [CNT_W-1:0]    error_count_q, error_count_d;
    logic [LAT_W-1:0]    min_latency_q, min_latency_d;
    logic                locked_q,      locked_d;

    logic [MAX_LAT:0]    w_taps;
    logic                w_err_search;
    logic                w_err_lock;
    logic                w_step;
    logic [c_WERR_W-1:0] w_win_err_final;

    // Tap d of w_taps is the reference bit presented d strobes ago
    assign w_taps          = {ref_sr_q, bus.i_ref_bit};
    assign w_err_search    = bus.i_rx_bit ^ w_taps[cand_q];
    assign w_err_lock      = bus.i_rx_bit ^ w_taps[min_latency_q];
    assign w_step          = bus.i_valid & bus.enable;
    assign w_win_err_final = win_err_q + c_WERR_W'(w_err_search);

    // Next-state: delay line on every strobe, everything else only when enabled
    always_comb begin
        state_d       = state_q;
        ref_sr_d      = ref_sr_q;
        cand_d        = cand_q;
        best_lat_d    = best_lat_q;
        best_err_d    = best_err_q;
        win_cnt_d     = win_cnt_q;
        win_err_d     = win_err_q;
        bit_count_d   = bit_count_q;
        error_count_d = error_count_q;
        min_latency_d = min_latency_q;
        locked_d      = locked_q;

        if (bus.i_valid) begin
            ref_sr_d = {ref_sr_q[MAX_LAT-2:0], bus.i_ref_bit};
        end

        if (w_step) begin
            case (state_q)
                ST_SEARCH: begin
                    if (win_cnt_q == c_WIN_LAST) begin
                        if (w_win_err_final == '0) begin
                            // A clean window is as good as it gets: lock now
                            min_latency_d = cand_q;
                            locked_d      = 1'b1;
                            state_d       = ST_LOCK;
                            win_cnt_d     = '0;
                            win_err_d     = '0;
                        end else begin
                            // Strict compare keeps the lower latency on ties
                            if (w_win_err_final < best_err_q) begin
                                best_err_d = w_win_err_final;
                                best_lat_d = cand_q;
                            end
                            if (cand_q == c_MAX_LAT) begin
                                min_latency_d = best_lat_d;
                                locked_d      = 1'b1;
                                state_d       = ST_LOCK;
                            end else begin
                                cand_d = cand_q + 1'b1;
                            end
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = w_win_err_final;
                    end
                end
                ST_LOCK: begin
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                    if (w_err_lock && (error_count_q != '1)) begin
                        error_count_d = error_count_q + 1'b1;
                    end
`ifdef BER_RESYNC_EN
                    // Window counters are reused as block trackers while locked
                    if (win_cnt_q == c_WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if ((win_err_q + c_WERR_W'(w_err_lock)) > c_WIN_HALF) begin
                            state_d       = ST_SEARCH;
                            bit_count_d   = '0;
                            error_count_d = '0;
                            cand_d        = '0;
                            locked_d      = 1'b0;
                            best_err_d    = '1;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_q + c_WERR_W'(w_err_lock);
                    end
`endif
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SEARCH;
            ref_sr_q      <= '0;
            cand_q        <= '0;
            best_lat_q    <= '0;
            best_err_q    <= '1;
            win_cnt_q     <= '0;
            win_err_q     <= '0;
            bit_count_q   <= '0;
            error_count_q <= '0;
            min_latency_q <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_sr_q      <= ref_sr_d;
            cand_q        <= cand_d;
            best_lat_q    <= best_lat_d;
            best_err_q    <= best_err_d;
            win_cnt_q     <= win_cnt_d;
            win_err_q     <= win_err_d;
            bit_count_q   <= bit_count_d;
            error_count_q <= error_count_d;
            min_latency_q <= min_latency_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.error_count = error_count_q;
    assign bus.bit_count   = bit_count_q;
    assign bus.min_latency = min_latency_q;
    assign bus.locked      = locked_q;

endmodule

`default_nettype wire
